// File: rtl/secded_pkg.sv
// Shared types and default geometry for the SECDED decode engine:
// FSM state encoding, decode-result record and result-word packing.
package secded_pkg;

  localparam int unsigned SRC_BASE_DEF  = 64;
  localparam int unsigned DST_BASE_DEF  = 94;
  localparam int unsigned NUM_WORDS_DEF = 15;

  typedef enum logic [2:0] {
    IDLE,
    RD_LO,
    RD_HI,
    DECODE,
    WR_LO,
    WR_HI,
    DONE
  } state_t;

  typedef struct packed {
    logic        dbl;
    logic        sec;
    logic [11:1] data;
  } decode_t;

  function automatic logic [15:0] pack_result(input decode_t r);
    return {r.dbl, r.sec, 3'b000, r.data};
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational check/correct of one extended-Hamming (16,11) codeword.
// Define SECDED_SEC_FLAG_EN to report corrected single-bit errors in the sec flag.
module secded_syndrome
  import secded_pkg::*;
(
  input  logic [15:0] codeword,
  output decode_t     result
);

  logic [3:0]  syndrome;
  logic        parity;
  logic [15:0] fixed;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    syndrome = '0;
    for (int k = 1; k < 16; k++) begin
      if (codeword[k]) syndrome ^= 4'(k);
    end
    parity = ^codeword;

    // Odd overall parity means one flipped bit; syndrome 0 points at p16 itself.
    fixed = codeword;
    if (parity) fixed[syndrome] = ~codeword[syndrome];

    result.dbl = (syndrome != 4'd0) && !parity;
`ifdef SECDED_SEC_FLAG_EN
    result.sec = parity && (syndrome != 4'd0);
`else
    result.sec = 1'b0;
`endif
    result.data = {fixed[15:9], fixed[7:5], fixed[3]};
  end

endmodule

// File: rtl/secded_decode_engine.sv
// Walks NUM_WORDS codewords from SRC_BASE, decodes each and writes results to DST_BASE.
// Honours SECDED_SEC_FLAG_EN through secded_syndrome.
module secded_decode_engine
  import secded_pkg::*;
#(
  parameter int unsigned SRC_BASE  = SRC_BASE_DEF,
  parameter int unsigned DST_BASE  = DST_BASE_DEF,
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       ack,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  localparam int unsigned CNT_W = 7;
  localparam logic [7:0]       SRC_B = 8'(SRC_BASE);
  localparam logic [7:0]       DST_B = 8'(DST_BASE);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(NUM_WORDS - 1);

  state_t           state, next_state;
  logic [CNT_W-1:0] word_cnt;
  logic [7:0]       word_off;
  logic [7:0]       cw_lo, cw_hi;
  decode_t          dec_d, dec_q;
  logic [15:0]      result_word;

  secded_syndrome u_syndrome (
    .codeword ({cw_hi, cw_lo}),
    .result   (dec_d)
  );

  // Byte offset of the current word; wraps modulo 256 with the base add.
  assign word_off    = {word_cnt, 1'b0};
  assign result_word = pack_result(dec_q);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = RD_LO;
      RD_LO:   next_state = RD_HI;
      RD_HI:   next_state = DECODE;
      DECODE:  next_state = WR_LO;
      WR_LO:   next_state = WR_HI;
      WR_HI:   next_state = (word_cnt == LAST) ? DONE : RD_LO;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt <= '0;
      cw_lo    <= '0;
      cw_hi    <= '0;
      dec_q    <= '0;
      ack      <= 1'b0;
    end else begin
      ack <= (next_state == DONE);
      case (state)
        IDLE:    if (next_state == RD_LO) word_cnt <= '0;
        RD_LO:   cw_lo <= mem_rd_data;
        RD_HI:   cw_hi <= mem_rd_data;
        DECODE:  dec_q <= dec_d;
        WR_HI:   if (next_state == RD_LO) word_cnt <= word_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  // Memory port is a pure decode of state, so reset forces it to zero at once.
  always_comb begin
    mem_addr    = '0;
    mem_wr_en   = 1'b0;
    mem_wr_data = '0;
    case (state)
      RD_LO: mem_addr = SRC_B + word_off;
      RD_HI: mem_addr = SRC_B + word_off + 8'd1;
      WR_LO: begin
        mem_addr    = DST_B + word_off;
        mem_wr_en   = 1'b1;
        mem_wr_data = result_word[7:0];
      end
      WR_HI: begin
        mem_addr    = DST_B + word_off + 8'd1;
        mem_wr_en   = 1'b1;
        mem_wr_data = result_word[15:8];
      end
      default: ;
    endcase
  end

endmodule
